// File: rtl/shift_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arbiter_pkg
//  Description : Shared constants and types for the shared-shifter arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_arbiter_pkg;

  localparam int SHIFT_W = 32;
  localparam int SHAMT_W = 5;

  // The response stage has two states; resp_valid is simply "stage is FULL".
  typedef enum logic [0:0] {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_e;

endpackage : shift_arbiter_pkg
`default_nettype wire

// File: rtl/shift_arbiter_right_shift.sv
`default_nettype none
// ============================================================================
//  Module      : RightShift
//  Description : Combinational arithmetic right shifter (sign fill).
//  Revision    : 1.0 - initial release
// ============================================================================
module RightShift #(
  parameter int W  = 32,
  parameter int SW = 5
) (
  input  logic [W-1:0]  data_i,
  input  logic [SW-1:0] shamt_i,
  output logic [W-1:0]  result_o
);

  // Vacated upper bits are filled with data_i[W-1].
  assign result_o = W'($signed(data_i) >>> shamt_i);

endmodule : RightShift
`default_nettype wire

// File: rtl/shift_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Search begins one past the
//                pointer and wraps; first valid requester wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  winner_o,
  output logic             found_o
);

  // Walk the requesters in priority order starting after the pointer.
  always_comb begin
    int idx;
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!found_o && valid_i[idx]) begin
        winner_o = ID_W'(idx);
        found_o  = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arbiter
//  Description : Round-robin sharing of one arithmetic right shifter among
//                N_REQ requesters, with a one-entry registered response stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [SHIFT_W*N_REQ-1:0]   req_data_i,
  input  logic [SHAMT_W*N_REQ-1:0]   req_shamt_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic                       resp_valid_o,
  output logic [SHIFT_W-1:0]         resp_data_o,
  output logic [ID_W-1:0]            resp_id_o,
  input  logic                       resp_ready_i
);

  resp_state_e          state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [SHIFT_W-1:0]   resp_data_q, resp_data_d;
  logic [ID_W-1:0]      resp_id_q, resp_id_d;

  logic [ID_W-1:0]      winner;
  logic                 found;
  logic                 free;
  logic                 xfer;
  logic [SHIFT_W-1:0]   sel_data;
  logic [SHAMT_W-1:0]   sel_shamt;
  logic [SHIFT_W-1:0]   shifted;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .valid_i  (req_valid_i),
    .ptr_i    (last_grant_q),
    .winner_o (winner),
    .found_o  (found)
  );

  // Stage can take a new result if empty or being drained this cycle.
  // Reset gates ready so nothing is granted while reset is held.
  assign free = (state_q == RESP_EMPTY) | resp_ready_i;
  assign xfer = found & free & ~rst_i;

  // Grant vector and operand mux; both steered only by the winner index.
  always_comb begin
    req_ready_o = '0;
    sel_data    = '0;
    sel_shamt   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        req_ready_o[i] = xfer;
        sel_data       = req_data_i[i*SHIFT_W +: SHIFT_W];
        sel_shamt      = req_shamt_i[i*SHAMT_W +: SHAMT_W];
      end
    end
  end

  RightShift #(
    .W  (SHIFT_W),
    .SW (SHAMT_W)
  ) u_shift (
    .data_i   (sel_data),
    .shamt_i  (sel_shamt),
    .result_o (shifted)
  );

  // Next-state for the response stage, pointer and payload.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    case (state_q)
      RESP_EMPTY: if (xfer) state_d = RESP_FULL;
      RESP_FULL:  if (!xfer && resp_ready_i) state_d = RESP_EMPTY;
      default:    state_d = RESP_EMPTY;
    endcase
    if (xfer) begin
      last_grant_d = winner;
      resp_data_d  = shifted;
      resp_id_d    = winner;
    end
  end

  // State registers; reset leaves the pointer so requester 0 wins first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RESP_EMPTY;
      last_grant_q <= ID_W'(N_REQ - 1);
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign resp_valid_o = (state_q == RESP_FULL);
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = resp_id_q;

endmodule : shift_arbiter
`default_nettype wire
